// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock/reset sequencer.
// Optional lock-loss statistics are enabled by `define PLL_LOCK_STATS_EN.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    // Width of a counter that must hold every terminal count of the sequencer.
    function automatic int unsigned cnt_width(input int unsigned rst_pulse,
                                              input int unsigned lock_timeout,
                                              input int unsigned stable_cycles);
        int unsigned m;
        m = rst_pulse;
        if (lock_timeout > m) m = lock_timeout;
        if (stable_cycles > m) m = stable_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync.sv
// Multi-flop bit synchronizer with synchronous active-high reset, used for the PLL locked input.
// Unaffected by `define PLL_LOCK_STATS_EN.
module pll_lock_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset pulse / lock wait / lock qualification sequencer driving the core reset.
// `define PLL_LOCK_STATS_EN adds the saturating o_lock_loss_cnt port.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE     = 16,
    parameter int unsigned LOCK_TIMEOUT  = 500000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       i_clk_sys,
    input  logic       i_reset,
    input  logic       i_pll_locked,
    output logic       o_pll_rst,
    output logic       o_core_reset,
    output logic       o_pll_ready,
`ifdef PLL_LOCK_STATS_EN
    output logic [7:0] o_lock_loss_cnt,
`endif
    output logic [1:0] o_seq_state
);

    localparam int unsigned CW = cnt_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    logic          w_locked_s;
    seq_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pll_rst;
    logic          r_core_reset;
    logic          r_pll_ready;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_async (i_pll_locked),
        .o_sync  (w_locked_s)
    );

    // r_cnt counts completed cycles in the current state; every transition clears it.
    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_pll_rst    <= 1'b1;
            r_core_reset <= 1'b1;
            r_pll_ready  <= 1'b0;
        end else begin
            r_pll_ready <= 1'b0;
            unique case (r_state)
                PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        r_state   <= WAIT_LOCK;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (w_locked_s) begin
                        r_state <= STABLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        r_state   <= PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE: begin
                    if (!w_locked_s) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        r_state      <= RUN;
                        r_cnt        <= '0;
                        r_core_reset <= 1'b0;
                        r_pll_ready  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!w_locked_s) begin
                        r_state      <= PLL_RST;
                        r_cnt        <= '0;
                        r_pll_rst    <= 1'b1;
                        r_core_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= PLL_RST;
                    r_cnt        <= '0;
                    r_pll_rst    <= 1'b1;
                    r_core_reset <= 1'b1;
                end
            endcase
        end
    end

`ifdef PLL_LOCK_STATS_EN
    logic [7:0] r_lock_loss_cnt;

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_lock_loss_cnt <= 8'h00;
        end else if (r_state == RUN && !w_locked_s && r_lock_loss_cnt != 8'hFF) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'h01;
        end
    end

    assign o_lock_loss_cnt = r_lock_loss_cnt;
`endif

    assign o_pll_rst    = r_pll_rst;
    assign o_core_reset = r_core_reset;
    assign o_pll_ready  = r_pll_ready;
    assign o_seq_state  = r_state;

endmodule
